// File: rtl/fp32_subtractor_seq_if.sv
// Operand/result handshake bundle for fp32_subtractor_seq.
// The producer/consumer side uses the master modport; the subtractor uses the slave modport.
interface fp32_subtractor_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp32_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (a - b, round-to-nearest-even).
// Optional macro FP32_SUB_FTZ_EN: flush denormal inputs and denormal results to signed zero.
module fp32_subtractor_seq (
  input  logic                clk,
  input  logic                rst_n,
  fp32_subtractor_seq_if.slave bus
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;          // subtrahend with its sign already inverted
  logic        sign_q, sign_d;
  logic [9:0]  exp_q, exp_d;      // wide enough that rounding carry past 254 cannot wrap
  logic [26:0] xf_q, xf_d;
  logic [26:0] yf_q, yf_d;
  logic        sub_q, sub_d;
  logic [27:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  flags_q, flags_d;

  // Operand decode for UNPACK.
  logic        sa, sb;
  logic [7:0]  ea_raw, eb_raw, ea, eb;
  logic [23:0] ma, mb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge_b;

  assign sa     = a_q[31];
  assign sb     = b_q[31];
  assign ea_raw = a_q[30:23];
  assign eb_raw = b_q[30:23];
  assign ea     = (ea_raw == 8'd0) ? 8'd1 : ea_raw;
  assign eb     = (eb_raw == 8'd0) ? 8'd1 : eb_raw;

`ifdef FP32_SUB_FTZ_EN
  assign ma = (ea_raw == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
  assign mb = (eb_raw == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
`else
  assign ma = {ea_raw != 8'd0, a_q[22:0]};
  assign mb = {eb_raw != 8'd0, b_q[22:0]};
`endif

  assign a_nan  = (ea_raw == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (eb_raw == 8'hFF) && (b_q[22:0] != 23'd0);
  assign a_inf  = (ea_raw == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (eb_raw == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_zero = (ma == 24'd0);
  assign b_zero = (mb == 24'd0);
  assign a_ge_b = {ea, ma} >= {eb, mb};

  // Alignment of the smaller operand into a 24+G/R/S field.
  logic        sx, sy;
  logic [7:0]  ex, ey, shamt;
  logic [23:0] mx, my;
  logic [26:0] y_ext, y_shift, y_lost, y_aligned;

  assign sx        = a_ge_b ? sa : sb;
  assign sy        = a_ge_b ? sb : sa;
  assign ex        = a_ge_b ? ea : eb;
  assign ey        = a_ge_b ? eb : ea;
  assign mx        = a_ge_b ? ma : mb;
  assign my        = a_ge_b ? mb : ma;
  assign shamt     = ex - ey;
  assign y_ext     = {my, 3'b000};
  assign y_shift   = y_ext >> shamt;
  assign y_lost    = y_ext & ~(27'h7FF_FFFF << shamt);
  assign y_aligned = {y_shift[26:1], y_shift[0] | (|y_lost)};

  // Round-to-nearest-even on the normalized field held in acc_q[26:0].
  logic        round_up, inexact;
  logic [24:0] rnd_sum;
  logic [23:0] rnd_mant;
  logic [9:0]  rnd_exp;

  assign inexact  = |acc_q[2:0];
  assign round_up = acc_q[2] & (acc_q[1] | acc_q[0] | acc_q[3]);
  assign rnd_sum  = {1'b0, acc_q[26:3]} + {24'd0, round_up};
  assign rnd_mant = rnd_sum[24] ? rnd_sum[24:1] : rnd_sum[23:0];
  assign rnd_exp  = exp_q + {9'd0, rnd_sum[24]};

  always_comb begin
    // NOTE: every _d starts as its _q so no branch of the case can infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    xf_d     = xf_q;
    yf_d     = yf_q;
    sub_d    = sub_q;
    acc_d    = acc_q;
    result_d = result_q;
    flags_d  = flags_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = {~bus.b[31], bus.b[30:0]};
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
          result_d = QNAN;
          flags_d  = 3'b100;
          state_d  = DONE;
        end else if (a_inf) begin
          result_d = {sa, 8'hFF, 23'd0};
          flags_d  = 3'b000;
          state_d  = DONE;
        end else if (b_inf) begin
          result_d = {sb, 8'hFF, 23'd0};
          flags_d  = 3'b000;
          state_d  = DONE;
        end else if (a_zero && b_zero) begin
          // -0 only when a is -0 and b is +0 (b's stored sign is already inverted).
          result_d = {sa & sb, 31'd0};
          flags_d  = 3'b000;
          state_d  = DONE;
        end else begin
          sign_d  = sx;
          exp_d   = {2'b00, ex};
          xf_d    = {mx, 3'b000};
          yf_d    = y_aligned;
          sub_d   = (sx != sy);
          state_d = ADD;
        end
      end

      ADD: begin
        acc_d   = sub_q ? ({1'b0, xf_q} - {1'b0, yf_q})
                        : ({1'b0, xf_q} + {1'b0, yf_q});
        state_d = NORM;
      end

      NORM: begin
        if (acc_q[27]) begin
          acc_d   = {1'b0, acc_q[27:2], acc_q[1] | acc_q[0]};
          exp_d   = exp_q + 10'd1;
          state_d = ROUND;
        end else if (acc_q == 28'd0) begin
          result_d = 32'd0;
          flags_d  = 3'b000;
          state_d  = DONE;
        end else if (!acc_q[26] && (exp_q > 10'd1)) begin
          acc_d = acc_q << 1;
          exp_d = exp_q - 10'd1;
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        if (rnd_exp >= 10'd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          flags_d  = 3'b011;
        end else if (!rnd_mant[23]) begin
`ifdef FP32_SUB_FTZ_EN
          result_d = {sign_q, 31'd0};
          flags_d  = 3'b001;
`else
          result_d = {sign_q, 8'd0, rnd_mant[22:0]};
          flags_d  = {2'b00, inexact};
`endif
        end else begin
          result_d = {sign_q, rnd_exp[7:0], rnd_mant[22:0]};
          flags_d  = {2'b00, inexact};
        end
        state_d = DONE;
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      xf_q     <= '0;
      yf_q     <= '0;
      sub_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      xf_q     <= xf_d;
      yf_q     <= yf_d;
      sub_q    <= sub_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fp32_subtractor_seq.sv
// Self-checking bench for fp32_subtractor_seq: directed vectors, backpressure, mid-op reset,
// and random operands checked against an exact wide-integer reference of a - b.
module tb_fp32_subtractor_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  fp32_subtractor_seq_if bus ();

  fp32_subtractor_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, want);
    end
  endtask

  // Operand value as an exact integer in units of 2^-149.
  function automatic logic [299:0] scaled(input logic [31:0] v);
    logic [23:0] m;
    int          e;
    e = int'(v[30:23]);
    if (e == 0) begin
`ifdef FP32_SUB_FTZ_EN
      m = 24'd0;
`else
      m = {1'b0, v[22:0]};
`endif
      e = 1;
    end else begin
      m = {1'b1, v[22:0]};
    end
    return 300'(m) << (e - 1);
  endfunction

  // Exact difference, then a single RNE rounding to binary32.
  task automatic ref_model(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic [2:0] f);
    logic         sa, sb, sr, a_nan, b_nan, a_inf, b_inf;
    logic [299:0] va, vb, mag, mant, rem, half, one;
    int           p, sh;
    one   = 300'd1;
    sa    = a[31];
    sb    = ~b[31];
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    va    = scaled(a);
    vb    = scaled(b);
    r     = 32'd0;
    f     = 3'b000;
    sr    = 1'b0;
    mag   = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      r = 32'h7FC0_0000;
      f = 3'b100;
    end else if (a_inf) begin
      r = {sa, 8'hFF, 23'd0};
    end else if (b_inf) begin
      r = {sb, 8'hFF, 23'd0};
    end else if (va == '0 && vb == '0) begin
      r = {sa & sb, 31'd0};
    end else begin
      if (sa == sb) begin
        mag = va + vb; sr = sa;
      end else if (va >= vb) begin
        mag = va - vb; sr = sa;
      end else begin
        mag = vb - va; sr = sb;
      end
      if (mag != '0) begin
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p <= 23) begin
          r = {sr, mag[30:0]};
`ifdef FP32_SUB_FTZ_EN
          if (p < 23) begin
            r = {sr, 31'd0};
            f = 3'b001;
          end
`endif
        end else begin
          sh   = p - 23;
          mant = mag >> sh;
          rem  = mag & ((one << sh) - one);
          half = one << (sh - 1);
          if (rem > half || (rem == half && mant[0])) mant = mant + one;
          if (mant[24]) begin
            mant = mant >> 1;
            sh++;
          end
          if (sh + 1 >= 255) begin
            r = {sr, 8'hFF, 23'd0};
            f = 3'b011;
          end else begin
            r = {sr, 8'(sh + 1), mant[22:0]};
            f = {2'b00, rem != '0};
          end
        end
      end
    end
  endtask

  // One complete transaction; want_lat < 0 means latency is only range-checked.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic use_want, input logic [31:0] want_r, input logic [2:0] want_f,
                       input int want_lat, input logic hold, input string name);
    logic [31:0] er;
    logic [2:0]  ef;
    logic [31:0] held;
    int          lat;
    int          waitc;
    if (use_want) begin
      er = want_r;
      ef = want_f;
    end else begin
      ref_model(a, b, er, ef);
    end
    waitc = 0;
    while (!bus.in_ready && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = hold ? 1'b0 : 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({name, ".in_ready_busy"}, bus.in_ready, 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, ".out_valid"}, bus.out_valid, 1'b1);
    if (want_lat >= 0) check({name, ".latency"}, lat, want_lat);
    else check({name, ".latency_in_range"}, (lat >= 1 && lat <= 28), 1'b1);
    check({name, ".result"}, bus.result, er);
    check({name, ".flags"}, bus.flags, ef);
    if (hold) begin
      held = bus.result;
      repeat (3) begin
        @(posedge clk); #1;
        check({name, ".held_result"}, bus.result, held);
        check({name, ".held_in_ready"}, bus.in_ready, 1'b0);
        check({name, ".held_out_valid"}, bus.out_valid, 1'b1);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({name, ".out_valid_drop"}, bus.out_valid, 1'b0);
    check({name, ".in_ready_back"}, bus.in_ready, 1'b1);
  endtask

  function automatic logic [31:0] rand_special();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7F80_0000;
      3:       return 32'hFF80_0000;
      4:       return 32'h7FC0_0000;
      5:       return 32'h7F7F_FFFF;
      6:       return 32'h0080_0000;
      default: return 32'h0000_0001;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    int          mode, e;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    #1;
    check("rst.in_ready", bus.in_ready, 1'b1);
    check("rst.out_valid", bus.out_valid, 1'b0);
    check("rst.result", bus.result, 32'd0);
    check("rst.flags", bus.flags, 3'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(32'h4040_0000, 32'h3F80_0000, 1, 32'h4000_0000, 3'b000, 4,  1, "sub3m1");
    do_op(32'h3F80_0000, 32'h3F7F_FFFF, 1, 32'h3380_0000, 3'b000, 28, 0, "k24");
    do_op(32'h4000_0000, 32'h4000_0000, 1, 32'h0000_0000, 3'b000, 3,  0, "exact_zero");
    do_op(32'h8000_0000, 32'h0000_0000, 1, 32'h8000_0000, 3'b000, 1,  0, "negzero");
    do_op(32'h0000_0000, 32'h8000_0000, 1, 32'h0000_0000, 3'b000, 1,  0, "poszero");
    do_op(32'h7F80_0000, 32'h7F80_0000, 1, 32'h7FC0_0000, 3'b100, 1,  0, "inf_inf");
    do_op(32'h7FC0_0001, 32'h3F80_0000, 1, 32'h7FC0_0000, 3'b100, 1,  0, "nan_in");
    do_op(32'h7F80_0000, 32'hFF80_0000, 1, 32'h7F80_0000, 3'b000, 1,  0, "inf_plus_inf");
    do_op(32'h3F80_0000, 32'h7F80_0000, 1, 32'hFF80_0000, 3'b000, 1,  0, "minus_inf");
    do_op(32'h3F80_0000, 32'hB380_0000, 1, 32'h3F80_0000, 3'b001, 4,  0, "tie_even");
    do_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, 1, 32'h7F80_0000, 3'b011, 4,  1, "overflow");
`ifdef FP32_SUB_FTZ_EN
    do_op(32'h0000_0001, 32'h0000_0000, 1, 32'h0000_0000, 3'b000, 1,  0, "denorm_ftz");
`else
    do_op(32'h0000_0001, 32'h0000_0000, 1, 32'h0000_0001, 3'b000, 4,  0, "denorm");
`endif

    // Reset while the long normalization is still in progress.
    do_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, 1, 32'h7F80_0000, 3'b011, 4, 0, "pre_reset");
    bus.a        = 32'h3F80_0000;
    bus.b        = 32'h3F7F_FFFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("norm.busy", bus.in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst.in_ready", bus.in_ready, 1'b1);
    check("midrst.out_valid", bus.out_valid, 1'b0);
    check("midrst.result", bus.result, 32'd0);
    check("midrst.flags", bus.flags, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'h4040_0000, 32'h3F80_0000, 1, 32'h4000_0000, 3'b000, 4, 0, "post_reset");

    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 4);
      ra   = $urandom;
      rb   = $urandom;
      case (mode)
        1: rb = {1'($urandom_range(0, 1)), ra[30:0] ^ 31'($urandom_range(0, 255))};
        2: begin
          ra = {ra[31], 8'd0, ra[22:0]};
          if ($urandom_range(0, 1) == 1) rb = {rb[31], 8'd0, rb[22:0]};
          else rb = {rb[31], 8'($urandom_range(1, 3)), rb[22:0]};
        end
        3: begin
          e  = $urandom_range(4, 250);
          ra = {ra[31], 8'(e), ra[22:0]};
          rb = {rb[31], 8'(e - int'($urandom_range(0, 3))), rb[22:0]};
        end
        4: begin
          if ($urandom_range(0, 1) == 1) ra = rand_special();
          else rb = rand_special();
        end
        default: ;
      endcase
      do_op(ra, rb, 0, 32'd0, 3'd0, -1, (i % 25) == 0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
